// File: rtl/blc_cal_ctrl.sv
// blc_cal_ctrl: black-level calibration sequencer; averages a pixel window over several frames
module blc_cal_ctrl #(
  parameter int PX_WIDTH        = 10,
  parameter int FRAME_RES_X     = 1920,
  parameter int FRAME_RES_Y     = 1080,
  parameter int WIN_X           = 0,
  parameter int WIN_Y           = 0,
  parameter int WIN_W_LOG2      = 4,
  parameter int WIN_H_LOG2      = 3,
  parameter int CAL_FRAMES_LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                mode_i,
  input  logic                cal_stb_i,
  input  logic [PX_WIDTH-1:0] man_bl_i,
  input  logic [PX_WIDTH-1:0] tdata_i,
  input  logic                tvalid_i,
  input  logic                tready_i,
  input  logic                tuser_i,
  input  logic                tlast_i,
  output logic [PX_WIDTH-1:0] bl_o,
  output logic [PX_WIDTH-1:0] cur_bl_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);
  localparam int SH = WIN_W_LOG2 + WIN_H_LOG2 + CAL_FRAMES_LOG2;
  localparam int SW = PX_WIDTH + SH;
  localparam int XW = $clog2(FRAME_RES_X + 1) + 1;
  localparam int YW = $clog2(FRAME_RES_Y + 1) + 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT_SOF = 2'd1, ACCUM = 2'd2, CALC = 2'd3;
  logic [1:0] state;
  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic [SW-1:0] sum, base_sum, new_sum;
  logic [CAL_FRAMES_LOG2:0] cnt, base_cnt, new_cnt;
  logic in_frame, beat, sof, win, frame_end, restart;
  assign busy_o = state != IDLE;
  assign done_o = state == CALC;
  // SOF beat is pixel (0,0) regardless of where the counters were left
  always_comb begin
    beat = tvalid_i && tready_i;
    sof = beat && tuser_i;
    px = sof ? '0 : x;
    py = sof ? '0 : y;
    win = beat && 32'(px) >= WIN_X && 32'(px) < WIN_X + 2**WIN_W_LOG2
               && 32'(py) >= WIN_Y && 32'(py) < WIN_Y + 2**WIN_H_LOG2;
    frame_end = beat && tlast_i && 32'(py) == FRAME_RES_Y - 1;
    // an SOF is a restart only when starting or when the previous frame never ended
    restart = sof && (state == WAIT_SOF || in_frame);
    base_sum = restart ? '0 : sum;
    base_cnt = restart ? '0 : cnt;
    new_sum = base_sum + (win ? SW'(tdata_i) : '0);
    new_cnt = base_cnt + {{CAL_FRAMES_LOG2{1'b0}}, frame_end};
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      sum <= '0;
      cnt <= '0;
      in_frame <= 1'b0;
      bl_o <= '0;
      cur_bl_o <= '0;
      err_o <= 1'b0;
    end else begin
      if (beat) begin
        x <= tlast_i ? '0 : px + 1'b1;
        y <= tlast_i ? py + 1'b1 : py;
      end
      if (frame_end) in_frame <= 1'b0;
      else if (sof) in_frame <= 1'b1;
      if (sof) bl_o <= mode_i ? cur_bl_o : man_bl_i;
      if (state == IDLE) begin
        if (cal_stb_i) begin
          state <= WAIT_SOF;
          err_o <= 1'b0;
        end
      end else if (state == CALC) begin
        cur_bl_o <= sum[SW-1:SH];
        state <= IDLE;
      end else if (beat && (state == ACCUM || sof)) begin
        sum <= new_sum;
        cnt <= new_cnt;
        if (state == ACCUM && restart) err_o <= 1'b1;
        state <= (frame_end && new_cnt[CAL_FRAMES_LOG2]) ? CALC : ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_blc_cal_ctrl.sv
// tb_blc_cal_ctrl: directed scoreboard bench for blc_cal_ctrl on a 16x8 frame
module tb_blc_cal_ctrl;
  logic clk = 0, rst_n = 0, mode = 0, cal_stb = 0;
  logic [9:0] man_bl = 0, tdata = 0;
  logic tvalid = 0, tready = 0, tuser = 0, tlast = 0;
  logic [9:0] bl, cur_bl;
  logic busy, done, err;
  int checks = 0, errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  blc_cal_ctrl #(
    .PX_WIDTH(10), .FRAME_RES_X(16), .FRAME_RES_Y(8), .WIN_X(0), .WIN_Y(0),
    .WIN_W_LOG2(2), .WIN_H_LOG2(1), .CAL_FRAMES_LOG2(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .mode_i(mode), .cal_stb_i(cal_stb), .man_bl_i(man_bl),
    .tdata_i(tdata), .tvalid_i(tvalid), .tready_i(tready), .tuser_i(tuser), .tlast_i(tlast),
    .bl_o(bl), .cur_bl_o(cur_bl), .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // window is columns 0-3 of rows 0-1
  task automatic lines(input logic [9:0] wv, input logic [9:0] ov, input int y0, input int y1, input bit stall);
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < 16; x++) begin
        tdata = (x < 4 && y < 2) ? wv : ov;
        tuser = (x == 0 && y == 0);
        tlast = (x == 15);
        do begin
          tvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
          tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
          @(posedge clk); #1;
        end while (!(tvalid && tready));
      end
    tvalid = 0; tready = 0; tuser = 0; tlast = 0;
  endtask

  task automatic cal(input int e);
    if (e >= 0) exp_q.push_back(e);
    cal_stb = 1;
    @(posedge clk); #1;
    cal_stb = 0;
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no calibration pending");
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          chk("cur_bl", cur_bl, e);
          chk("busy_after_done", busy, 0);
          chk("done_single_pulse", done, 0);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bl", bl, 0);
    chk("rst_cur_bl", cur_bl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    @(posedge clk); #1;
    // constant frames
    cal(64);
    lines(64, 64, 0, 7, 0);
    lines(64, 64, 0, 7, 0);
    wait_done();
    // window 10 then 13: 184 >> 4 = 11
    cal(11);
    lines(10, 500, 0, 7, 0);
    lines(13, 500, 0, 7, 0);
    wait_done();
    // start mid-frame: row 1 window pixels of 300 must be ignored
    lines(300, 300, 0, 0, 0);
    cal(64);
    lines(300, 300, 1, 7, 0);
    lines(64, 64, 0, 7, 0);
    lines(64, 64, 0, 7, 0);
    wait_done();
    chk("err_clean", err, 0);
    // manual / calibrated switching only on SOF
    mode = 0; man_bl = 5;
    lines(7, 7, 0, 7, 0);
    chk("bl_manual", bl, 5);
    lines(7, 7, 0, 3, 0);
    mode = 1;
    lines(7, 7, 4, 7, 0);
    chk("bl_hold_mid_frame", bl, 5);
    lines(7, 7, 0, 0, 0);
    chk("bl_calibrated", bl, 64);
    // unexpected SOF after 5 lines of frame 1
    cal(20);
    chk("err_cleared_by_cal", err, 0);
    lines(64, 64, 0, 7, 0);
    lines(64, 64, 0, 4, 0);
    lines(20, 20, 0, 0, 0);
    chk("err_set", err, 1);
    lines(20, 20, 1, 7, 0);
    lines(20, 20, 0, 7, 0);
    wait_done();
    chk("err_sticky", err, 1);
    // reset during accumulation
    cal(-1);
    chk("err_cleared_again", err, 0);
    lines(30, 30, 0, 2, 0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    chk("mid_rst_bl", bl, 0);
    chk("mid_rst_cur_bl", cur_bl, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    rst_n = 1;
    @(posedge clk); #1;
    // stalled streams
    cal(64);
    lines(64, 64, 0, 7, 1);
    lines(64, 64, 0, 7, 1);
    wait_done();
    cal(11);
    lines(10, 500, 0, 7, 1);
    lines(13, 500, 0, 7, 1);
    wait_done();
    lines(1, 1, 0, 0, 0);
    chk("bl_after_stall_cal", bl, 11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
